// File: rtl/addr_decode_pkg.sv
// Shared helpers for the rule-table address decoder.
// A packed rule is laid out MSB to LSB as: idx | start (base) | end (mask).
// No ports; provides the index-width function, rule field offsets and the
// rule width.
package addr_decode_pkg;

  // Index width never collapses to zero, even for a single target.
  function automatic int unsigned idx_width(input int unsigned no_indices);
    return (no_indices > 1) ? $clog2(no_indices) : 1;
  endfunction

  function automatic int unsigned rule_width(input int unsigned iw, input int unsigned aw);
    return iw + 2 * aw;
  endfunction

  // LSB offsets of each field inside one packed rule.
  function automatic int unsigned end_lsb(input int unsigned aw);
    return 0 * aw;
  endfunction

  function automatic int unsigned start_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned idx_lsb(input int unsigned aw);
    return 2 * aw;
  endfunction

  // Rule width for the default configuration (2 targets, 32-bit addresses).
  localparam int unsigned RuleWidth = 1 + 2 * 32;

endpackage

// File: rtl/addr_rule_match.sv
// Evaluates one decode rule against an address.
// Ports:
//   addr_i   address under test
//   start_i  range start (inclusive) or NAPOT base
//   end_i    range end (exclusive, 0 = top of space) or NAPOT mask
//   hit_o    rule matches the address
module addr_rule_match
  import addr_decode_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter bit          Napot     = 1'b0
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] start_i,
  input  logic [AddrWidth-1:0] end_i,
  output logic                 hit_o
);

  if (Napot) begin : g_napot
    // A zero mask compares no bits and therefore matches everything.
    assign hit_o = ((addr_i & end_i) == (start_i & end_i));
  end else begin : g_range
    // end == 0 opens the range up to the top of the address space.
    assign hit_o = (addr_i >= start_i) && ((addr_i < end_i) || (end_i == '0));
  end

endmodule

// File: rtl/addr_rule_decode.sv
// Rule-table address/ID decoder with registered outputs (one cycle latency).
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   addr_i            address or ID to decode
//   addr_map_i        packed rules, rule r at slice r
//   default_idx_i     index used when no rule matches
//   en_default_idx_i  enables default_idx_i
//   idx_o             decoded index
//   dec_valid_o       some rule matched
//   dec_error_o       no match and default disabled
module addr_rule_decode
  import addr_decode_pkg::*;
#(
  parameter int unsigned NoIndices = 2,
  parameter int unsigned NoRules   = 1,
  parameter int unsigned AddrWidth = 32,
  parameter bit          Napot     = 1'b0,
  localparam int unsigned IdxWidth = idx_width(NoIndices),
  localparam int unsigned RuleW    = rule_width(IdxWidth, AddrWidth),
  // Keep the map port at least one bit wide when the table is empty.
  localparam int unsigned MapW     = (NoRules > 0) ? NoRules * RuleW : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [MapW-1:0]      addr_map_i,
  input  logic [IdxWidth-1:0]  default_idx_i,
  input  logic                 en_default_idx_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 dec_valid_o,
  output logic                 dec_error_o
);

  localparam int unsigned NumSlots = (NoRules > 0) ? NoRules : 1;

  logic [NumSlots-1:0] hit;
  logic [IdxWidth-1:0] rule_idx [NumSlots];
  logic [IdxWidth-1:0] idx_d;
  logic                match;

  if (NoRules > 0) begin : g_rules
    for (genvar r = 0; r < NoRules; r++) begin : g_rule
      logic [AddrWidth-1:0] rule_start;
      logic [AddrWidth-1:0] rule_end;

      assign rule_idx[r] = addr_map_i[r*RuleW + idx_lsb(AddrWidth) +: IdxWidth];
      assign rule_start  = addr_map_i[r*RuleW + start_lsb(AddrWidth) +: AddrWidth];
      assign rule_end    = addr_map_i[r*RuleW + end_lsb(AddrWidth) +: AddrWidth];

      addr_rule_match #(
        .AddrWidth(AddrWidth),
        .Napot    (Napot)
      ) u_match (
        .addr_i (addr_i),
        .start_i(rule_start),
        .end_i  (rule_end),
        .hit_o  (hit[r])
      );

`ifndef SYNTHESIS
      // Checked on the clock so that transient input updates are ignored.
      always @(posedge clk_i) begin
        if (rst_ni) begin
          assert (int'(rule_idx[r]) < int'(NoIndices))
            else $warning("rule %0d idx %0d out of range", r, rule_idx[r]);
          if (!Napot) begin
            assert ((rule_end == '0) || (rule_end >= rule_start))
              else $warning("rule %0d has end below start and never matches", r);
          end
        end
      end
`endif
    end
  end else begin : g_no_rules
    assign hit         = '0;
    assign rule_idx[0] = '0;
  end

  // Later rules overwrite earlier ones, so the highest matching rule wins.
  always_comb begin
    idx_d = '0;
    match = 1'b0;
    for (int r = 0; r < int'(NoRules); r++) begin
      if (hit[r]) begin
        match = 1'b1;
        idx_d = rule_idx[r];
      end
    end
    if (!match && en_default_idx_i) begin
      idx_d = default_idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_o       <= '0;
      dec_valid_o <= 1'b0;
      dec_error_o <= 1'b0;
    end else begin
      idx_o       <= idx_d;
      dec_valid_o <= match;
      dec_error_o <= !match && !en_default_idx_i;
    end
  end

endmodule

// File: tb/tb_addr_rule_decode.sv
module tb_addr_rule_decode;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [33:0] map_r = '0;
  logic [33:0] map_n = '0;
  logic        en_def = 1'b0;
  logic        def_idx = 1'b0;

  logic idx_r, val_r, err_r;
  logic idx_n, val_n, err_n;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  addr_rule_decode #(
    .NoIndices(2), .NoRules(2), .AddrWidth(8), .Napot(1'b0)
  ) dut_r (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr), .addr_map_i(map_r),
    .default_idx_i(def_idx), .en_default_idx_i(en_def),
    .idx_o(idx_r), .dec_valid_o(val_r), .dec_error_o(err_r)
  );

  addr_rule_decode #(
    .NoIndices(2), .NoRules(2), .AddrWidth(8), .Napot(1'b1)
  ) dut_n (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr), .addr_map_i(map_n),
    .default_idx_i(def_idx), .en_default_idx_i(en_def),
    .idx_o(idx_n), .dec_valid_o(val_n), .dec_error_o(err_n)
  );

  function automatic logic [16:0] pack_rule(input logic i, input logic [7:0] s, input logic [7:0] e);
    return {i, s, e};
  endfunction

  // Reference decode: returns {idx, valid, error}. Searching from the top rule
  // downward, the first hit is the winner.
  function automatic logic [2:0] model(input bit napot, input logic [7:0] a,
                                       input logic [33:0] map, input logic en, input logic d);
    for (int r = 1; r >= 0; r--) begin
      logic [16:0] rule;
      int unsigned s, e, ad, top;
      bit hit;
      rule = map[r*17 +: 17];
      s = rule[15:8];
      e = rule[7:0];
      ad = a;
      if (napot) begin
        hit = 1'b1;
        for (int b = 0; b < 8; b++)
          if (e[b] && (ad[b] != s[b])) hit = 1'b0;
      end else begin
        top = (e == 0) ? 256 : e;
        hit = (ad >= s) && (ad < top);
      end
      if (hit) return {rule[16], 1'b1, 1'b0};
    end
    if (en) return {d, 1'b0, 1'b0};
    return 3'b001;
  endfunction

  task automatic drive(input logic [7:0] a, input logic e, input logic d);
    addr = a;
    en_def = e;
    def_idx = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    map_r = {pack_rule(1'b0, 8'h10, 8'h20), pack_rule(1'b1, 8'h00, 8'h10)};
    map_n = {pack_rule(1'b0, 8'h00, 8'hFF), pack_rule(1'b1, 8'h40, 8'hC0)};
    drive(8'h0F, 1'b0, 1'b0);
    drive(8'h0F, 1'b0, 1'b0);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b000)
      $display("FAIL reset_range: got %b exp %b", {idx_r, val_r, err_r}, 3'b000);
    else n_pass++;
    n_checks++;
    if ({idx_n, val_n, err_n} !== 3'b000)
      $display("FAIL reset_napot: got %b exp %b", {idx_n, val_n, err_n}, 3'b000);
    else n_pass++;
    rst_ni = 1'b1;
    drive(8'h0F, 1'b0, 1'b0);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b110)
      $display("FAIL reset_release: got %b exp %b", {idx_r, val_r, err_r}, 3'b110);
    else n_pass++;
  endtask

  task automatic test_range();
    map_r = {pack_rule(1'b0, 8'h10, 8'h20), pack_rule(1'b1, 8'h00, 8'h10)};
    drive(8'h0F, 1'b0, 1'b0);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b110)
      $display("FAIL range_0x0F: got %b exp %b", {idx_r, val_r, err_r}, 3'b110);
    else n_pass++;
    drive(8'h10, 1'b0, 1'b0);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b010)
      $display("FAIL range_end_exclusive: got %b exp %b", {idx_r, val_r, err_r}, 3'b010);
    else n_pass++;
    drive(8'h20, 1'b0, 1'b0);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b001)
      $display("FAIL range_0x20_nomatch: got %b exp %b", {idx_r, val_r, err_r}, 3'b001);
    else n_pass++;
  endtask

  task automatic test_overlap();
    map_r = {pack_rule(1'b0, 8'h20, 8'h30), pack_rule(1'b1, 8'h00, 8'h40)};
    drive(8'h25, 1'b0, 1'b0);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b010)
      $display("FAIL overlap_0x25: got %b exp %b", {idx_r, val_r, err_r}, 3'b010);
    else n_pass++;
    drive(8'h35, 1'b0, 1'b0);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b110)
      $display("FAIL overlap_0x35: got %b exp %b", {idx_r, val_r, err_r}, 3'b110);
    else n_pass++;
  endtask

  task automatic test_no_match();
    map_r = {pack_rule(1'b0, 8'h10, 8'h20), pack_rule(1'b1, 8'h00, 8'h10)};
    drive(8'h80, 1'b0, 1'b1);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b001)
      $display("FAIL nomatch_default_off: got %b exp %b", {idx_r, val_r, err_r}, 3'b001);
    else n_pass++;
    drive(8'h80, 1'b1, 1'b1);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b100)
      $display("FAIL nomatch_default_on: got %b exp %b", {idx_r, val_r, err_r}, 3'b100);
    else n_pass++;
  endtask

  task automatic test_wrap();
    map_r = {pack_rule(1'b0, 8'hF0, 8'hF0), pack_rule(1'b1, 8'hF0, 8'h00)};
    drive(8'hFF, 1'b0, 1'b0);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b110)
      $display("FAIL wrap_0xFF: got %b exp %b", {idx_r, val_r, err_r}, 3'b110);
    else n_pass++;
    drive(8'hEF, 1'b0, 1'b0);
    n_checks++;
    if ({idx_r, val_r, err_r} !== 3'b001)
      $display("FAIL wrap_below_start: got %b exp %b", {idx_r, val_r, err_r}, 3'b001);
    else n_pass++;
  endtask

  task automatic test_napot();
    map_n = {pack_rule(1'b0, 8'h00, 8'hFF), pack_rule(1'b1, 8'h40, 8'hC0)};
    drive(8'h7F, 1'b0, 1'b0);
    n_checks++;
    if ({idx_n, val_n, err_n} !== 3'b110)
      $display("FAIL napot_0x7F: got %b exp %b", {idx_n, val_n, err_n}, 3'b110);
    else n_pass++;
    drive(8'h80, 1'b0, 1'b0);
    n_checks++;
    if ({idx_n, val_n, err_n} !== 3'b001)
      $display("FAIL napot_0x80: got %b exp %b", {idx_n, val_n, err_n}, 3'b001);
    else n_pass++;
    map_n = {pack_rule(1'b0, 8'h12, 8'h00), pack_rule(1'b1, 8'h40, 8'hC0)};
    drive(8'h80, 1'b0, 1'b0);
    n_checks++;
    if ({idx_n, val_n, err_n} !== 3'b010)
      $display("FAIL napot_zero_mask: got %b exp %b", {idx_n, val_n, err_n}, 3'b010);
    else n_pass++;
  endtask

  // Rules and address change every cycle; each cycle is checked on both DUTs.
  task automatic test_back_to_back_random();
    logic [2:0] exp_r, exp_n;
    logic [7:0] s, e, a;
    logic [16:0] rr [2];
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        s = 8'($urandom_range(0, 255));
        e = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(int'(s), 255));
        rr[r] = pack_rule(1'($urandom), s, e);
      end
      map_r = {rr[1], rr[0]};
      e = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'(8'hFF << $urandom_range(0, 7));
      map_n = {pack_rule(1'($urandom), 8'($urandom), 8'($urandom)),
               pack_rule(1'($urandom), 8'($urandom), e)};
      case ($urandom_range(0, 3))
        0: a = rr[0][15:8];
        1: a = rr[1][7:0];
        2: a = rr[1][7:0] - 8'd1;
        default: a = 8'($urandom);
      endcase
      en_def = 1'($urandom);
      def_idx = 1'($urandom);
      exp_r = model(1'b0, a, map_r, en_def, def_idx);
      exp_n = model(1'b1, a, map_n, en_def, def_idx);
      drive(a, en_def, def_idx);
      n_checks++;
      if ({idx_r, val_r, err_r} !== exp_r)
        $display("FAIL rand_range[%0d] addr=%h map=%h: got %b exp %b", i, a, map_r,
                 {idx_r, val_r, err_r}, exp_r);
      else n_pass++;
      n_checks++;
      if ({idx_n, val_n, err_n} !== exp_n)
        $display("FAIL rand_napot[%0d] addr=%h map=%h: got %b exp %b", i, a, map_n,
                 {idx_n, val_n, err_n}, exp_n);
      else n_pass++;
      n_checks++;
      if ((val_r && err_r) || (val_n && err_n))
        $display("FAIL valid_error_exclusive[%0d]: got range=%b%b napot=%b%b exp not both set",
                 i, val_r, err_r, val_n, err_n);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_range();
    test_overlap();
    test_no_match();
    test_wrap();
    test_napot();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
